// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : alu_pkg
// Purpose  : Shared definitions for the ALU front end: op codes, the grounded
//            op value driven while idle, FSM state encoding, error-bit indices
//            and small op-classification helpers.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package alu_pkg;

   localparam logic [3:0] OP_ADD    = 4'd0;
   localparam logic [3:0] OP_MOD    = 4'd1;
   localparam logic [3:0] OP_DIV    = 4'd2;
   localparam logic [3:0] OP_MUL    = 4'd4;
   localparam logic [3:0] OP_SUB    = 4'd8;
   localparam logic [3:0] OP_GROUND = 4'b0011;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] EXEC = 2'd1;
   localparam logic [1:0] RESP = 2'd2;

   localparam int ERR_DZ  = 1;
   localparam int ERR_OVF = 0;

   function automatic logic op_is_legal(input logic [3:0] op);
      case (op)
         OP_ADD, OP_MOD, OP_DIV, OP_MUL, OP_SUB: return 1'b1;
         default:                                return 1'b0;
      endcase
   endfunction

   // Only the flag relevant to the op class is reported; illegal ops flag both.
   function automatic logic [1:0] err_select(input logic [3:0] op,
                                             input logic       ovf,
                                             input logic       dz);
      logic [1:0] e;
      e = 2'b00;
      case (op)
         OP_ADD, OP_SUB: e[ERR_OVF] = ovf;
         OP_DIV, OP_MOD: e[ERR_DZ]  = dz;
         OP_MUL:         e          = 2'b00;
         default:        e          = 2'b11;
      endcase
      return e;
   endfunction

endpackage : alu_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb2
// Purpose  : Two-input round-robin grant. A lone requester always wins; on a
//            tie the requester that was not granted last time wins.
// Ports    : valid[1:0]  in   request vector
//            last_grant  in   index of the most recently granted requester
//            grant[1:0]  out  one-hot grant (all zero when nothing requests)
// Revision : 1.0  initial release
// ============================================================================
module rr_arb2 (
   input  logic [1:0] valid,
   input  logic       last_grant,
   output logic [1:0] grant
);

   always_comb begin
      grant    = 2'b00;
      grant[0] = valid[0] & (~valid[1] |  last_grant);
      grant[1] = valid[1] & (~valid[0] | ~last_grant);
   end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_arbiter
// Purpose  : Sequential front end sharing one combinational ALU between two
//            requesters. Accepts one command at a time (round-robin), holds
//            the operands on the ALU for SETTLE_CYCLES edges, captures result
//            and error flags, and returns them on a tagged valid/ready port.
// Ports    : clk, rst_n                       clock, sync active-low reset
//            reqN_valid/ready/a/b/op          requester command channels
//            resp_valid/ready/id/result/err   tagged response channel
//            alu_a/alu_b/alu_op               operands driven to the ALU
//            alu_result/overflow/div_zero     ALU outputs
// Revision : 1.0  initial release
// ============================================================================
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int SETTLE_CYCLES = 2,
   parameter int DATA_W        = 16,
   parameter int RES_W         = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [DATA_W-1:0] req0_a,
   input  logic [DATA_W-1:0] req0_b,
   input  logic [3:0]        req0_op,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [DATA_W-1:0] req1_a,
   input  logic [DATA_W-1:0] req1_b,
   input  logic [3:0]        req1_op,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic              resp_id,
   output logic [RES_W-1:0]  resp_result,
   output logic [1:0]        resp_err,
   output logic [DATA_W-1:0] alu_a,
   output logic [DATA_W-1:0] alu_b,
   output logic [3:0]        alu_op,
   input  logic [RES_W-1:0]  alu_result,
   input  logic              alu_overflow,
   input  logic              alu_div_zero
);

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic              last_grant_q, last_grant_d;
   logic              resp_valid_q, resp_valid_d;
   logic              resp_id_q, resp_id_d;
   logic [RES_W-1:0]  resp_result_q, resp_result_d;
   logic [1:0]        resp_err_q, resp_err_d;
   logic [DATA_W-1:0] alu_a_q, alu_a_d;
   logic [DATA_W-1:0] alu_b_q, alu_b_d;
   logic [3:0]        alu_op_q, alu_op_d;

   logic [1:0]        grant;
   logic [1:0]        ready;
   logic              accept;

   rr_arb2 u_arb (
      .valid      ({req1_valid, req0_valid}),
      .last_grant (last_grant_q),
      .grant      (grant)
   );

   // Readies are held low while reset is asserted so nothing appears accepted
   // on an edge where reset wins anyway.
   assign ready      = grant & {2{rst_n && (state_q == IDLE)}};
   assign req0_ready = ready[0];
   assign req1_ready = ready[1];
   assign accept     = |ready;

   // State register (all flops).
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         cnt_q         <= 4'd0;
         last_grant_q  <= 1'b1;
         resp_valid_q  <= 1'b0;
         resp_id_q     <= 1'b0;
         resp_result_q <= '0;
         resp_err_q    <= 2'b00;
         alu_a_q       <= '0;
         alu_b_q       <= '0;
         alu_op_q      <= OP_GROUND;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         last_grant_q  <= last_grant_d;
         resp_valid_q  <= resp_valid_d;
         resp_id_q     <= resp_id_d;
         resp_result_q <= resp_result_d;
         resp_err_q    <= resp_err_d;
         alu_a_q       <= alu_a_d;
         alu_b_q       <= alu_b_d;
         alu_op_q      <= alu_op_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               state_d = EXEC;
               cnt_d   = CNT_INIT;
            end
         end
         EXEC: begin
            if (cnt_q != 4'd0) cnt_d   = cnt_q - 4'd1;
            else               state_d = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Datapath / output register updates.
   always_comb begin
      last_grant_d  = last_grant_q;
      resp_valid_d  = resp_valid_q;
      resp_id_d     = resp_id_q;
      resp_result_d = resp_result_q;
      resp_err_d    = resp_err_q;
      alu_a_d       = alu_a_q;
      alu_b_d       = alu_b_q;
      alu_op_d      = alu_op_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
               alu_a_d      = grant[1] ? req1_a  : req0_a;
               alu_b_d      = grant[1] ? req1_b  : req0_b;
               alu_op_d     = grant[1] ? req1_op : req0_op;
               last_grant_d = grant[1];
            end
         end
         EXEC: begin
            if (cnt_q == 4'd0) begin
               resp_valid_d  = 1'b1;
               // last_grant always names the owner of the in-flight command.
               resp_id_d     = last_grant_q;
               resp_result_d = op_is_legal(alu_op_q) ? alu_result : '0;
               resp_err_d    = err_select(alu_op_q, alu_overflow, alu_div_zero);
            end
         end
         RESP: begin
            if (resp_ready) begin
               resp_valid_d = 1'b0;
               alu_a_d      = '0;
               alu_b_d      = '0;
               alu_op_d     = OP_GROUND;
            end
         end
         default: begin
            resp_valid_d = 1'b0;
         end
      endcase
   end

   assign resp_valid  = resp_valid_q;
   assign resp_id     = resp_id_q;
   assign resp_result = resp_result_q;
   assign resp_err    = resp_err_q;
   assign alu_a       = alu_a_q;
   assign alu_b       = alu_b_q;
   assign alu_op      = alu_op_q;

endmodule : alu_arbiter
`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Sequential front end for the shared 16-bit combinational ALU (add, sub, mul, div, mod).
- Two requesters share the ALU. Arbitration is round-robin.
- For each accepted command, the block registers the operands and op code, drives the ALU for a programmable settle window, and captures the 32-bit result plus error flags.
- The captured result is returned on a tagged response port with a valid/ready handshake.

Parameters:
- SETTLE_CYCLES, 2, clock edges the ALU inputs are held before the result is captured; legal range 1 to 15.
- DATA_W, 16, operand width.
- RES_W, 32, result width.

Ports:
- clk  in  1  single system clock; all state updates on the rising edge.
- rst_n  in  1  synchronous, active-low reset, sampled on the rising edge of clk.
- req0_valid / req1_valid  in  1  requester command valid.
- req0_ready / req1_ready  out  1  command accepted when valid and ready are both high at a clock edge.
- req0_a, req0_b / req1_a, req1_b  in  DATA_W  operands.
- req0_op / req1_op  in  4  op code.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumer ready.
- resp_id  out  1  requester index (0 or 1) that owns the response.
- resp_result  out  RES_W  captured ALU result.
- resp_err  out  2  bit1 = divide-by-zero, bit0 = add/sub overflow.
- alu_a, alu_b  out  DATA_W  operands driven to the ALU.
- alu_op  out  4  op code driven to the ALU.
- alu_result  in  RES_W  ALU result.
- alu_overflow  in  1  ALU overflow flag.
- alu_div_zero  in  1  ALU divide-by-zero flag.

Behaviour:
- Reset (rst_n = 0 at an edge):
  - state goes to IDLE; last_grant = 1, so requester 0 wins first.
  - resp_valid = 0, resp_id = 0, resp_result = 0, resp_err = 0.
  - alu_a = 0, alu_b = 0, alu_op = 4'b0011 (grounded channel).
- Reset mid-operation: any in-flight command or pending response is discarded and no response is issued.
- States:
  - IDLE: no command in flight.
  - EXEC: holds a down-counter cnt of width 4.
  - RESP: response pending.
- Ready generation (combinational from state, valids and last_grant):
  - req_ready is high only in IDLE.
  - One valid only: that requester gets ready.
  - Both valid: the requester != last_grant gets ready. The other sees ready = 0.
  - Neither valid: both readies are 0.
- Accept edge (IDLE plus handshake):
  - register a, b, op into alu_a, alu_b, alu_op; record id; set last_grant = id.
  - cnt = SETTLE_CYCLES-1; go to EXEC.
- EXEC, each edge:
  - cnt > 0: decrement cnt.
  - cnt == 0: capture alu_result and error into the resp registers, assert resp_valid, go to RESP.
- Latency: resp_valid rises exactly SETTLE_CYCLES edges after the accept edge.
- ALU inputs are stable throughout EXEC and RESP. They return to 0 / 4'b0011 on the edge that leaves RESP.
- Legal op codes: 0 ADD, 1 MOD, 2 DIV, 4 MUL, 8 SUB.
- Error capture:
  - ADD/SUB: resp_err = {1'b0, alu_overflow}.
  - DIV/MOD: resp_err = {alu_div_zero, 1'b0}.
  - MUL: resp_err = 2'b00.
  - Illegal op: resp_result = 0 and resp_err = 2'b11 (the ALU is still sequenced normally).
- RESP:
  - resp_* outputs are held stable while resp_valid = 1 and resp_ready = 0.
  - On the resp handshake edge: resp_valid = 0, go to IDLE.
  - A new command cannot be accepted on that same edge. The earliest accept is the next edge, so maximum throughput is one command per SETTLE_CYCLES+2 edges.
- A requester dropping valid before its handshake is legal; no state change results.
- Operands are passed unmodified. Sign extension to RES_W is the ALU's job.

Decomposition:
- Shared package alu_pkg contains:
  - op-code constants OP_ADD, OP_MOD, OP_DIV, OP_MUL, OP_SUB and the OP_GROUND value 4'b0011;
  - the state encoding IDLE/EXEC/RESP;
  - error-bit indices ERR_DZ = 1 and ERR_OVF = 0.
- One sub-module, rr_arb2: two-input round-robin grant logic taking valids and last_grant, producing a one-hot grant.

Test Plan:
- Reset and idle:
  - Stimulus: rst_n = 0 for 3 edges with both valids high.
  - Response: both readies 0, resp_valid = 0, alu_op = 4'b0011; after release, req0_ready = 1.
- Add latency:
  - Stimulus: req0 a = 6, b = 9, op = 0 with SETTLE_CYCLES = 2.
  - Response: resp_valid exactly 2 edges after accept, resp_result = 15, resp_id = 0, resp_err = 00.
- Mul and div-by-zero:
  - Stimulus: req1 op = 4 with 6, 9; then op = 2 with 6, 0.
  - Response: results 54 / err 00, then 32'hFFFFFFFF / err 10.
- Fairness:
  - Stimulus: both requesters hold valid for 4 commands, resp_ready tied high.
  - Response: resp_id sequence 0, 1, 0, 1; no accept occurs on the resp handshake edge.
- Backpressure:
  - Stimulus: resp_ready = 0 for 5 cycles, with req1 valid the whole time.
  - Response: resp_* held constant; req1_ready stays 0 until the response drains.
- Illegal op and reset mid-operation:
  - Stimulus: op = 5.
  - Response: result 0, err 11.
  - Stimulus: rst_n low during EXEC.
  - Response: no resp_valid ever issues for that command.
